// File: rtl/nes_pad_if.sv
// nes_pad_if: pad-side serial lines and CPU-side button byte of nes_pad_reader.
// With NES_PAD_EDGE_EN defined the bundle also carries btn_press.
interface nes_pad_if;
    logic       pad_serial;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] controller_data;
    logic       data_valid;
`ifdef NES_PAD_EDGE_EN
    logic [7:0] btn_press;
`endif

    modport master (
        input  pad_serial,
`ifdef NES_PAD_EDGE_EN
        output btn_press,
`endif
        output pad_latch,
        output pad_clk,
        output controller_data,
        output data_valid
    );

    modport slave (
        output pad_serial,
`ifdef NES_PAD_EDGE_EN
        input  btn_press,
`endif
        input  pad_latch,
        input  pad_clk,
        input  controller_data,
        input  data_valid
    );
endinterface

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls an NES serial game pad and presents a stable active-high button byte.
// Define NES_PAD_EDGE_EN to add btn_press (buttons newly pressed since the previous scan).
module nes_pad_reader #(
    parameter int HALF     = 4,
    parameter int POLL_GAP = 16
) (
    input  logic      clk,
    input  logic      reset,
    nes_pad_if.master pad
);
    localparam int MAX_CNT = (2 * HALF > POLL_GAP) ? 2 * HALF : POLL_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(POLL_GAP - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             sync_p0, sync_p1;
    logic             latch_q, latch_next;
    logic             sclk_q, sclk_next;
    logic             valid_q, valid_next;
    logic [7:0]       data_q, data_next;
`ifdef NES_PAD_EDGE_EN
    logic [7:0]       press_q, press_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift_reg <= '0;
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            latch_q   <= 1'b0;
            sclk_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
`ifdef NES_PAD_EDGE_EN
            press_q   <= '0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shift_reg <= shift_next;
            sync_p0   <= pad.pad_serial;
            sync_p1   <= sync_p0;
            latch_q   <= latch_next;
            sclk_q    <= sclk_next;
            valid_q   <= valid_next;
            data_q    <= data_next;
`ifdef NES_PAD_EDGE_EN
            press_q   <= press_next;
`endif
        end
    end

    // Outputs are decoded from the next state so the pad lines are clean register outputs.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        shift_next = shift_reg;
        unique case (state)
            IDLE: begin
                if (cnt == GAP_LAST) begin
                    state_next = LATCH;
                    cnt_next   = '0;
                end
            end
            LATCH: begin
                if (cnt == LATCH_LAST) begin
                    state_next = LOW;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            end
            LOW: begin
                if (cnt == HALF_LAST) begin
                    shift_next[idx] = ~sync_p1;
                    cnt_next        = '0;
                    state_next      = (idx == 3'd7) ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (cnt == HALF_LAST) begin
                    idx_next   = idx + 3'd1;
                    cnt_next   = '0;
                    state_next = LOW;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        latch_next = (state_next == LATCH);
        sclk_next  = (state_next == HIGH);
        valid_next = (state_next == DONE);
        data_next  = (state_next == DONE) ? shift_next : data_q;
`ifdef NES_PAD_EDGE_EN
        press_next = (state_next == DONE) ? (shift_next & ~data_q) : 8'h00;
`endif
    end

    assign pad.pad_latch       = latch_q;
    assign pad.pad_clk         = sclk_q;
    assign pad.data_valid      = valid_q;
    assign pad.controller_data = data_q;
`ifdef NES_PAD_EDGE_EN
    assign pad.btn_press       = press_q;
`endif
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: scan timing, button decode, reset abort and hold behaviour of nes_pad_reader.
// A behavioural NES pad drives pad_serial; expected bytes queue up as the pad is set.
module tb_nes_pad_reader;
    localparam int HALF     = 4;
    localparam int POLL_GAP = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] buttons = 8'h00;
    logic [7:0] pad_sr = 8'hFF;
    logic       pad_clk_d = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q [$];

    nes_pad_if pad ();

    nes_pad_reader #(.HALF(HALF), .POLL_GAP(POLL_GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .pad   (pad)
    );

    always #5 clk = ~clk;

    // Pad model: parallel load while latched, shift on each rising pad_clk, bit0 (A) first.
    assign pad.pad_serial = pad_sr[0];
    always @(posedge clk) begin
        pad_clk_d <= pad.pad_clk;
        if (pad.pad_latch)
            pad_sr <= ~buttons;
        else if (pad.pad_clk && !pad_clk_d)
            pad_sr <= {1'b1, pad_sr[7:1]};
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic wait_dv(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (pad.data_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_latch(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (pad.pad_latch) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (pad.controller_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", pad.controller_data); end
        total++; if (pad.data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pad.data_valid); end
        total++; if (pad.pad_latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b want=0", pad.pad_latch); end
        total++; if (pad.pad_clk !== 1'b0) begin bad++; $display("FAIL reset_clk got=%b want=0", pad.pad_clk); end
    endtask

    task automatic test_first_scan();
        int         lat_rise = -1, lat2 = -1, lat_len = 0, dv_cyc = -1, dv_cnt = 0;
        bit         prev_lat = 1'b0;
        logic [7:0] got = 8'hxx, exp;
        buttons = 8'h00;
        exp_q.push_back(8'h00);
        reset = 1'b0;
        for (int i = 0; i < 130 && lat2 < 0; i++) begin
            @(negedge clk);
            if (pad.pad_latch && !prev_lat) begin
                if (lat_rise < 0) lat_rise = cyc;
                else              lat2 = cyc;
            end
            if (pad.pad_latch && lat2 < 0) lat_len++;
            if (pad.data_valid) begin dv_cnt++; dv_cyc = cyc; got = pad.controller_data; end
            prev_lat = pad.pad_latch;
        end
        exp = exp_q.pop_front();
        total++; if (lat_rise !== 16) begin bad++; $display("FAIL first_latch_rise got=%0d want=16", lat_rise); end
        total++; if (lat_len !== 8) begin bad++; $display("FAIL first_latch_len got=%0d want=8", lat_len); end
        total++; if (dv_cyc !== 84) begin bad++; $display("FAIL first_valid_cycle got=%0d want=84", dv_cyc); end
        total++; if (dv_cnt !== 1) begin bad++; $display("FAIL first_valid_count got=%0d want=1", dv_cnt); end
        total++; if (got !== exp) begin bad++; $display("FAIL first_data got=%h want=%h", got, exp); end
        total++; if (lat2 !== 101) begin bad++; $display("FAIL second_latch_rise got=%0d want=101", lat2); end
    endtask

    task automatic test_a_start();
        bit         ok;
        logic [7:0] exp;
        buttons = 8'h09;
        exp_q.push_back(8'h09);
        wait_dv(200, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || pad.controller_data !== exp) begin bad++; $display("FAIL a_start_data got=%h want=%h seen=%0d", pad.controller_data, exp, ok); end
        @(negedge clk);
        total++; if (pad.data_valid !== 1'b0) begin bad++; $display("FAIL a_start_single_pulse got=%b want=0", pad.data_valid); end
    endtask

    task automatic test_all_pressed();
        bit         ok, dv_seen = 1'b0, prev_clk = 1'b0;
        int         rises = 0, hlen = 0, bad_len = 0, overlap = 0;
        logic [7:0] exp;
        buttons = 8'hFF;
        exp_q.push_back(8'hFF);
        wait_latch(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL all_latch_timeout got=none want=latch"); end
        for (int i = 0; i < 120 && !dv_seen; i++) begin
            @(negedge clk);
            if (pad.pad_clk && !prev_clk) rises++;
            if (pad.pad_clk) hlen++;
            if (!pad.pad_clk && prev_clk) begin
                if (hlen != HALF) bad_len++;
                hlen = 0;
            end
            if (pad.pad_clk && pad.pad_latch) overlap++;
            prev_clk = pad.pad_clk;
            if (pad.data_valid) dv_seen = 1'b1;
        end
        exp = exp_q.pop_front();
        total++; if (rises !== 7) begin bad++; $display("FAIL all_clk_rises got=%0d want=7", rises); end
        total++; if (bad_len !== 0) begin bad++; $display("FAIL all_clk_high_len bad_pulses=%0d want=0", bad_len); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL all_overlap got=%0d want=0", overlap); end
        total++; if (pad.pad_clk !== 1'b0 || pad.pad_latch !== 1'b0) begin bad++; $display("FAIL all_done_lines clk=%b latch=%b want=0/0", pad.pad_clk, pad.pad_latch); end
        total++; if (!dv_seen || pad.controller_data !== exp) begin bad++; $display("FAIL all_data got=%h want=%h seen=%0d", pad.controller_data, exp, dv_seen); end
    endtask

    task automatic test_reset_mid_scan();
        bit         ok;
        int         dv_early = 0, rise = -1;
        logic [7:0] exp;
        buttons = 8'h09;
        exp_q.push_back(8'h09);
        wait_dv(200, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || pad.controller_data !== exp) begin bad++; $display("FAIL abort_prior_data got=%h want=%h", pad.controller_data, exp); end
        buttons = 8'hFF;
        wait_latch(200, ok);
        repeat (42) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (pad.pad_clk !== 1'b0 || pad.pad_latch !== 1'b0) begin bad++; $display("FAIL abort_lines clk=%b latch=%b want=0/0", pad.pad_clk, pad.pad_latch); end
        total++; if (pad.controller_data !== 8'h00) begin bad++; $display("FAIL abort_data got=%h want=00", pad.controller_data); end
        reset = 1'b0;
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 60 && rise < 0; i++) begin
            @(negedge clk);
            if (pad.data_valid) dv_early++;
            if (pad.pad_latch) rise = cyc;
        end
        total++; if (dv_early !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d want=0", dv_early); end
        total++; if (rise !== 16) begin bad++; $display("FAIL abort_relatch got=%0d want=16", rise); end
        wait_dv(200, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || cyc !== 84 || pad.controller_data !== exp) begin bad++; $display("FAIL abort_next_scan got=%h at %0d want=%h at 84", pad.controller_data, cyc, exp); end
    endtask

    task automatic test_hold_idle();
        bit         ok, dv_seen = 1'b0;
        int         changed = 0;
        logic [7:0] exp;
        buttons = 8'h09;
        exp_q.push_back(8'h09);
        wait_dv(200, ok);
        exp = exp_q.pop_front();
        total++; if (!ok || pad.controller_data !== exp) begin bad++; $display("FAIL hold_first got=%h want=%h", pad.controller_data, exp); end
        @(negedge clk);
        buttons = 8'h01;
        exp_q.push_back(8'h01);
        for (int i = 0; i < 200 && !dv_seen; i++) begin
            if (pad.controller_data !== 8'h09) changed++;
            @(negedge clk);
            if (pad.data_valid) dv_seen = 1'b1;
        end
        exp = exp_q.pop_front();
        total++; if (changed !== 0) begin bad++; $display("FAIL hold_stable changes=%0d want=0", changed); end
        total++; if (!dv_seen || pad.controller_data !== exp) begin bad++; $display("FAIL hold_update got=%h want=%h", pad.controller_data, exp); end
    endtask

    task automatic test_edge_press();
`ifdef NES_PAD_EDGE_EN
        logic [7:0] seq [4] = '{8'h00, 8'h09, 8'h0B, 8'h02};
        logic [7:0] prev = 8'h00, exp_btn, exp;
        bit         ok;
        int         stray;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (pad.btn_press !== 8'h00) begin bad++; $display("FAIL edge_reset got=%h want=00", pad.btn_press); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            buttons = seq[i];
            exp_q.push_back(seq[i]);
            exp_btn = seq[i] & ~prev;
            prev    = seq[i];
            stray   = 0;
            ok      = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(negedge clk);
                if (pad.data_valid) ok = 1'b1;
                else if (pad.btn_press !== 8'h00) stray++;
            end
            exp = exp_q.pop_front();
            total++; if (!ok || pad.controller_data !== exp) begin bad++; $display("FAIL edge_data[%0d] got=%h want=%h", i, pad.controller_data, exp); end
            total++; if (pad.btn_press !== exp_btn) begin bad++; $display("FAIL edge_press[%0d] got=%h want=%h", i, pad.btn_press, exp_btn); end
            total++; if (stray !== 0) begin bad++; $display("FAIL edge_idle[%0d] nonzero_cycles=%0d want=0", i, stray); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_a_start();
        test_all_pressed();
        test_reset_mid_scan();
        test_hold_idle();
        test_edge_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
